// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic Bernstein engine: FSM encoding and
// the Fibonacci LFSR feedback taps for each supported width.
package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit n-1 set for each tap x^n of a maximal-length polynomial.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// W-bit Fibonacci LFSR; a zero seed is replaced by all-ones so the
// register can never lock up in the all-zero state.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] r_state;
    logic         w_fb;

    assign w_fb  = ^(r_state & TAPS);
    assign state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '1;
        end else if (load) begin
            r_state <= (seed == '0) ? '1 : seed;
        end else if (enable) begin
            r_state <= {r_state[W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/sc_bernstein_engine.sv
// Stochastic-computing Bernstein polynomial evaluator: each accepted sample
// selects coefficient k = popcount(x_in) and emits (rnd < coef[k]).
module sc_bernstein_engine
    import sc_pkg::*;
#(
    parameter int N_IN     = 3,
    parameter int W        = 6,
    parameter int LEN_LOG2 = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        seed_we,
    input  logic [W-1:0]                seed_data,
    input  logic                        coef_we,
    input  logic [$clog2(N_IN+1)-1:0]   coef_addr,
    input  logic [W:0]                  coef_data,
    input  logic                        x_valid,
    input  logic [N_IN-1:0]             x_in,
    output logic                        busy,
    output logic                        z_valid,
    output logic                        z,
    output logic                        done,
    output logic [LEN_LOG2:0]           ones_count,
    output state_t                      o_dbg_state
);

    localparam int CW = $clog2(N_IN+1);
    localparam logic [LEN_LOG2:0] MAX_ONES = {1'b1, {LEN_LOG2{1'b0}}};

    state_t              r_state;
    state_t              w_next;
    logic [W:0]          r_coef [N_IN+1];
    logic [LEN_LOG2-1:0] r_cnt;
    logic [LEN_LOG2:0]   r_ones;
    logic                r_z;
    logic                r_z_valid;
    logic                w_idle;
    logic                w_accept;
    logic                w_last;
    logic                w_bit;
    logic [CW-1:0]       w_k;
    logic [W-1:0]        w_rnd;

    // Valid/ready: the engine is ready only in RUN; a sample transfers on
    // any RUN cycle with x_valid=1, and z_valid marks its result one cycle later.

    sc_lfsr #(.W(W)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (w_accept),
        .load   (seed_we && w_idle),
        .seed   (seed_data),
        .state  (w_rnd)
    );

    always_comb begin
        w_k = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_k = w_k + CW'(x_in[i]);
        end
    end

    // Zero-extended compare: coef >= 2^W always wins, coef = 0 never does.
    assign w_bit  = ({1'b0, w_rnd} < r_coef[w_k]);
    assign w_last = (r_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_accept && w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == ST_RUN);
        done     = (r_state == ST_DONE);
        w_idle   = (r_state == ST_IDLE);
        w_accept = (r_state == ST_RUN) && x_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= N_IN; i++) begin
                r_coef[i] <= '0;
            end
        end else if (coef_we && w_idle && (int'(coef_addr) <= N_IN)) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_ones    <= '0;
            r_z       <= 1'b0;
            r_z_valid <= 1'b0;
        end else begin
            r_z_valid <= w_accept;
            r_z       <= w_accept && w_bit;
            if (w_idle && start) begin
                r_cnt  <= '0;
                r_ones <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_bit && (r_ones != MAX_ONES)) begin
                    r_ones <= r_ones + 1'b1;
                end
            end
        end
    end

    assign z           = r_z;
    assign z_valid     = r_z_valid;
    assign ones_count  = r_ones;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sc_bernstein_engine.sv
// Directed bench for sc_bernstein_engine: every z bit is checked against an
// independent LFSR/coefficient model, plus run timing and ones_count checks.
module tb_sc_bernstein_engine;

    localparam int NS = 256;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               seed_we;
    logic [5:0]         seed_data;
    logic               coef_we;
    logic [1:0]         coef_addr;
    logic [6:0]         coef_data;
    logic               x_valid;
    logic [2:0]         x_in;
    logic               busy;
    logic               z_valid;
    logic               z;
    logic               done;
    logic [8:0]         ones_count;
    sc_pkg::state_t     dbg_state;

    int                 errors = 0;
    int                 checks = 0;
    logic [5:0]         m_lfsr;
    logic [6:0]         m_coef [4];
    logic [2:0]         x_vec [NS];
    logic [0:0]         exp_q [$];

    sc_bernstein_engine #(.N_IN(3), .W(6), .LEN_LOG2(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seed_we     (seed_we),
        .seed_data   (seed_data),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .x_valid     (x_valid),
        .x_in        (x_in),
        .busy        (busy),
        .z_valid     (z_valid),
        .z           (z),
        .done        (done),
        .ones_count  (ones_count),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // x^6 + x^5 + 1: feedback is bit5 xor bit4, shifted in at bit 0.
    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[4]};
    endfunction

    function automatic int pop3(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; seed_we = 1'b0; seed_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; x_valid = 1'b0; x_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        m_lfsr = 6'h3F;
        for (int i = 0; i < 4; i++) m_coef[i] = '0;
    endtask

    task automatic write_coef(input int addr, input logic [6:0] data);
        coef_addr = 2'(addr); coef_data = data; coef_we = 1'b1;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        m_coef[addr] = data;
    endtask

    task automatic write_seed(input logic [5:0] s);
        seed_data = s; seed_we = 1'b1;
        @(posedge clk);
        #1;
        seed_we = 1'b0;
        m_lfsr = (s == 6'h00) ? 6'h3F : s;
    endtask

    task automatic fill_x(input bit rnd, input logic [2:0] val);
        for (int i = 0; i < NS; i++) x_vec[i] = rnd ? 3'($urandom_range(0, 7)) : val;
    endtask

    // Cycle 1 is the cycle start is held; with continuous samples done is
    // high in cycle 258, with samples every other cycle in cycle 513.
    task automatic run_stream(input bit toggle, input bit poke, output int done_cyc, output int ones_exp);
        int cyc;
        int sent;
        int nvalid;
        logic e;
        exp_q.delete();
        ones_exp = 0; done_cyc = -1; sent = 0; nvalid = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; coef_we = 1'b0; seed_we = 1'b0;
        cyc = 2;
        while (cyc < 1200) begin
            if (z_valid) begin
                nvalid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL z_extra: cycle %0d z_valid=1 with no sample pending", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (z !== e) begin
                        errors++;
                        $display("FAIL z_bit: sample %0d got %b expected %b", nvalid - 1, z, e);
                    end
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (poke && cyc >= 3 && cyc <= 6) begin
                coef_we = 1'b1; coef_addr = 2'(cyc - 3); coef_data = 7'd64;
                seed_we = 1'b1; seed_data = 6'h15; start = 1'b1;
            end else begin
                coef_we = 1'b0; seed_we = 1'b0; start = 1'b0;
            end
            if (sent < NS && (!toggle || (cyc % 2) == 0)) begin
                x_valid = 1'b1;
                x_in    = x_vec[sent];
                e       = ({1'b0, m_lfsr} < m_coef[pop3(x_vec[sent])]);
                exp_q.push_back(e);
                ones_exp += int'(e);
                m_lfsr = lfsr_next(m_lfsr);
                sent++;
            end else begin
                x_valid = 1'b0;
                x_in    = '0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        x_valid = 1'b0; x_in = '0; coef_we = 1'b0; seed_we = 1'b0; start = 1'b0;
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end
        checks++;
        if (nvalid != NS) begin
            errors++;
            $display("FAIL z_valid_count: got %0d expected %0d", nvalid, NS);
        end
        checks++;
        if (ones_count !== 9'(ones_exp)) begin
            errors++;
            $display("FAIL ones_at_done: got %0d expected %0d", ones_count, ones_exp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || dbg_state !== sc_pkg::ST_IDLE || ones_count !== 9'(ones_exp)) begin
            errors++;
            $display("FAIL after_done: done=%b state=%0d ones=%0d expected done=0 state=0 ones=%0d",
                     done, dbg_state, ones_count, ones_exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy !== 1'b0 || z !== 1'b0 || z_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b z=%b z_valid=%b done=%b expected all 0", busy, z, z_valid, done);
        end
        checks++;
        if (ones_count !== 9'd0 || dbg_state !== sc_pkg::ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: ones=%0d state=%0d expected 0 and IDLE", ones_count, dbg_state);
        end
    endtask

    task automatic test_coef_zero();
        int dc;
        int oe;
        do_reset();
        fill_x(1'b1, 3'b000);
        run_stream(1'b0, 1'b0, dc, oe);
        checks++;
        if (dc != 258) begin
            errors++;
            $display("FAIL zero_done_cycle: got %0d expected 258", dc);
        end
        checks++;
        if (ones_count !== 9'd0) begin
            errors++;
            $display("FAIL zero_ones: got %0d expected 0", ones_count);
        end
    endtask

    task automatic test_coef_full();
        int dc;
        int oe;
        for (int i = 0; i < 4; i++) write_coef(i, 7'd64);
        fill_x(1'b1, 3'b000);
        run_stream(1'b0, 1'b0, dc, oe);
        checks++;
        if (ones_count !== 9'd256 || dc != 258) begin
            errors++;
            $display("FAIL full_ones: ones=%0d done_cycle=%0d expected 256 and 258", ones_count, dc);
        end
    endtask

    task automatic test_popcount_select();
        int dc;
        int oe;
        write_coef(0, 7'd0); write_coef(1, 7'd0); write_coef(2, 7'd64); write_coef(3, 7'd0);
        fill_x(1'b0, 3'b011);
        run_stream(1'b0, 1'b0, dc, oe);
        checks++;
        if (ones_count !== 9'd256) begin
            errors++;
            $display("FAIL k2_select: got %0d expected 256", ones_count);
        end
        fill_x(1'b0, 3'b111);
        run_stream(1'b0, 1'b0, dc, oe);
        checks++;
        if (ones_count !== 9'd0) begin
            errors++;
            $display("FAIL k3_reject: got %0d expected 0", ones_count);
        end
    endtask

    task automatic test_toggle();
        int dc;
        int oe_cont;
        int oe_tog;
        write_seed(6'h2A);
        write_coef(0, 7'd10); write_coef(1, 7'd30); write_coef(2, 7'd45); write_coef(3, 7'd64);
        fill_x(1'b1, 3'b000);
        run_stream(1'b0, 1'b0, dc, oe_cont);
        write_seed(6'h2A);
        run_stream(1'b1, 1'b0, dc, oe_tog);
        checks++;
        if (dc != 513) begin
            errors++;
            $display("FAIL toggle_done_cycle: got %0d expected 513", dc);
        end
        checks++;
        if (ones_count !== 9'(oe_cont)) begin
            errors++;
            $display("FAIL toggle_ones: got %0d expected %0d (continuous run)", ones_count, oe_cont);
        end
    endtask

    task automatic test_reset_abort();
        int dc;
        int oe;
        bit seen_done;
        for (int i = 0; i < 4; i++) write_coef(i, 7'd64);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; x_valid = 1'b1; x_in = 3'b101;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (ones_count !== 9'd100) begin
            errors++;
            $display("FAIL abort_pre_count: got %0d expected 100", ones_count);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (dbg_state !== sc_pkg::ST_IDLE || ones_count !== 9'd0 || busy !== 1'b0 || z_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: state=%0d ones=%0d busy=%b z_valid=%b expected IDLE,0,0,0",
                     dbg_state, ones_count, busy, z_valid);
        end
        x_valid = 1'b0; x_in = '0;
        m_lfsr = 6'h3F;
        for (int i = 0; i < 4; i++) m_coef[i] = '0;
        seen_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL abort_no_done: got done=1 after aborted run expected 0");
        end
        fill_x(1'b1, 3'b000);
        run_stream(1'b0, 1'b1, dc, oe);
        checks++;
        if (ones_count !== 9'd0 || dc != 258) begin
            errors++;
            $display("FAIL run_writes_dropped: ones=%0d done_cycle=%0d expected 0 and 258", ones_count, dc);
        end
    endtask

    task automatic test_random_model();
        int dc;
        int oe;
        do_reset();
        write_seed(6'h2A);
        write_coef(0, 7'd0); write_coef(1, 7'd21); write_coef(2, 7'd50); write_coef(3, 7'd100);
        fill_x(1'b1, 3'b000);
        run_stream(1'b0, 1'b0, dc, oe);
        write_seed(6'h00);
        for (int i = 0; i < 4; i++) write_coef(i, 7'd32);
        fill_x(1'b1, 3'b000);
        run_stream(1'b0, 1'b0, dc, oe);
    endtask

    task automatic test_back_to_back();
        int dc;
        int oe;
        write_coef(0, 7'd0);
        fill_x(1'b0, 3'b000);
        coef_addr = 2'd0; coef_data = 7'd64; coef_we = 1'b1;
        m_coef[0] = 7'd64;
        run_stream(1'b0, 1'b0, dc, oe);
        checks++;
        if (ones_count !== 9'd256) begin
            errors++;
            $display("FAIL start_with_write: got %0d expected 256", ones_count);
        end
        fill_x(1'b1, 3'b000);
        run_stream(1'b0, 1'b0, dc, oe);
        checks++;
        if (dc != 258) begin
            errors++;
            $display("FAIL back_to_back_done: got %0d expected 258", dc);
        end
    endtask

    initial begin
        test_reset();
        test_coef_zero();
        test_coef_full();
        test_popcount_select();
        test_toggle();
        test_reset_abort();
        test_random_model();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_bernstein_engine.md
SC_BERNSTEIN_ENGINE -- requirements
Module: sc_bernstein_engine

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of stochastic input streams; polynomial degree; N_IN+1 coefficients.
REQ-002 SHALL have parameter W, default 6: random-number and coefficient precision in bits (4..16).
REQ-003 SHALL have parameter LEN_LOG2, default 8: stream length per run = 2^LEN_LOG2 accepted samples.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: begin a run when in IDLE.
REQ-007 SHALL have port seed_we, input, 1: load seed_data into the LFSR.
REQ-008 SHALL have port seed_data, input, W: LFSR seed.
REQ-009 SHALL have port coef_we, input, 1: write a coefficient register.
REQ-010 SHALL have port coef_addr, input, clog2(N_IN+1): coefficient index.
REQ-011 SHALL have port coef_data, input, W+1: coefficient; probability = coef/2^W, saturating at 2^W.
REQ-012 SHALL have port x_valid, input, 1: x_in carries a sample this cycle.
REQ-013 SHALL have port x_in, input, N_IN: one bit from each input bitstream.
REQ-014 SHALL have port busy, output, 1: high in RUN.
REQ-015 SHALL have port z_valid, output, 1: z carries an output bit.
REQ-016 SHALL have port z, output, 1: output bitstream bit.
REQ-017 SHALL have port done, output, 1: one-cycle pulse at end of run.
REQ-018 SHALL have port ones_count, output, LEN_LOG2+1: number of 1s produced in the last run.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE.
REQ-020 IDLE->RUN when start=1; sample counter and ones_count cleared on that edge.
REQ-021 In RUN, a sample SHALL be accepted on every cycle x_valid=1; cycles with x_valid=0 SHALL advance neither the counter nor the LFSR.
REQ-022 Per accepted sample: k = popcount(x_in), range 0..N_IN; coefficient bit = (rnd < coef[k]) with rnd the current W-bit LFSR state; coef >= 2^W always yields 1; coef = 0 always yields 0.
REQ-023 z and z_valid SHALL be registered: latency exactly 1 cycle from acceptance; z_valid=0 otherwise.
REQ-024 ones_count SHALL increment in the same cycle z is registered with value 1, and SHALL never wrap (max 2^LEN_LOG2).
REQ-025 RUN->DONE on the edge accepting the 2^LEN_LOG2-th sample; done=1 for exactly the single DONE cycle; DONE->IDLE unconditionally.
REQ-026 ones_count SHALL include the final sample when done is high and SHALL hold until the next start.
REQ-027 LFSR: Fibonacci, maximal-length for W, steps once per accepted sample; an all-zero seed SHALL be replaced by all-ones.
REQ-028 coef_we and seed_we SHALL take effect only in IDLE; writes in RUN or DONE are dropped.
REQ-029 start in RUN or DONE SHALL be ignored; start and coef_we in the same IDLE cycle: write completes and run starts.

Reset
REQ-030 Reset SHALL force: state IDLE, busy=0, z=0, z_valid=0, done=0, ones_count=0, sample counter=0, LFSR=all-ones, all coefficients=0.
REQ-031 Reset SHALL override every other input, including mid-run; no done pulse follows an aborted run.

Structure
REQ-032 Shared package sc_pkg SHALL hold the FSM state encodings and the LFSR tap table indexed by W (W=6: x^6+x^5+1).
REQ-033 The LFSR SHALL be a separate sub-module sc_lfsr, with ports clk, reset, enable, load, seed, state.

Verification
REQ-034 Reset, all coef=0, start, x_valid=1 continuously -> z=0 on every sample, done on cycle 258 after start, ones_count=0.
REQ-035 All coef=64 (W=6), start, 256 samples -> z=1 on every sample, ones_count=256.
REQ-036 coef[k]=64 for k=2 only, x_in=3'b011 fixed, others 0 -> ones_count=256; x_in=3'b111 -> ones_count=0.
REQ-037 x_valid toggling 1/0 every cycle -> done 512 cycles after start, ones_count identical to the continuous run with the same seed and coefficients.
REQ-038 Reset asserted at sample 100 of a run -> next cycle IDLE, ones_count=0, no done; then coef_we during RUN -> coefficient unchanged on readback through a directed run.
REQ-039 Random x_in, seed 6'h2A, arbitrary coefficients -> ones_count and z stream bit-exact against a bench model.
